// File: rtl/song_player.sv
// Song ROM sequencer. It walks one 128-word region and holds each note or rest for D external
// ticks, then stops at the end marker or loops back to the start of the region.
module song_player (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  song_sel,
  input  logic        loop,
  input  logic        tick,
  output logic [8:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [5:0]  note,
  output logic        note_on,
  output logic        note_strobe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

  state_e     state;
  logic [5:0] cnt;

  logic       is_rest;
  logic [5:0] pitch;
  logic [5:0] dur;
  logic       at_last;
  logic [8:0] next_addr;
  logic [8:0] base_addr;
  logic       advance;
  logic       end_hit;
  logic       unused_bits;

  assign is_rest     = rom_data[15];
  assign pitch       = rom_data[14:9];
  assign dur         = is_rest ? rom_data[14:9] : rom_data[8:3];
  assign unused_bits = ^rom_data[2:0];
  assign at_last     = (rom_addr[6:0] == 7'h7f);
  // Only the low 7 bits advance, so playback can never cross into a neighbouring song.
  assign next_addr   = {rom_addr[8:7], rom_addr[6:0] + 7'd1};
  assign base_addr   = {rom_addr[8:7], 7'd0};

  // Running off the last word of a region is handled exactly like an end marker.
  always_comb begin
    advance = 1'b0;
    end_hit = 1'b0;
    unique case (state)
      StFetch: begin
        if (dur == 6'd0) begin
          if (is_rest || at_last) end_hit = 1'b1;
          else                    advance = 1'b1;
        end
      end
      StPlay: begin
        if (tick && cnt == 6'd1) begin
          if (at_last) end_hit = 1'b1;
          else         advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= 6'd0;
      rom_addr    <= 9'd0;
      note        <= 6'd0;
      note_on     <= 1'b0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state   <= StIdle;
        cnt     <= 6'd0;
        note    <= 6'd0;
        note_on <= 1'b0;
        busy    <= 1'b0;
      end else if (start) begin
        state    <= StFetch;
        rom_addr <= {song_sel, 7'd0};
        cnt      <= 6'd0;
        note     <= 6'd0;
        note_on  <= 1'b0;
        busy     <= 1'b1;
      end else if (end_hit) begin
        cnt     <= 6'd0;
        note    <= 6'd0;
        note_on <= 1'b0;
        if (loop) begin
          rom_addr <= base_addr;
          state    <= StFetch;
        end else begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (advance) begin
        rom_addr <= next_addr;
        note     <= 6'd0;
        note_on  <= 1'b0;
        state    <= StFetch;
      end else begin
        unique case (state)
          StFetch: begin
            cnt   <= dur;
            state <= StPlay;
            if (is_rest) begin
              note    <= 6'd0;
              note_on <= 1'b0;
            end else begin
              note        <= pitch;
              note_on     <= 1'b1;
              note_strobe <= 1'b1;
            end
          end
          StPlay: begin
            if (tick) cnt <= cnt - 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: small ROM model, free-running tick every 4 clocks, checks by
// immediate assertions at each step.
module tb_song_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  song_sel;
  logic        loop;
  logic        tick;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic [5:0]  note;
  logic        note_on;
  logic        note_strobe;
  logic        busy;
  logic        done;

  logic [15:0] rom [512];
  logic        zero_r1;
  logic        tick_en;
  int          tdiv;
  int          total;
  int          bad;
  int          done_seen;

  song_player dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .song_sel    (song_sel),
    .loop        (loop),
    .tick        (tick),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note        (note),
    .note_on     (note_on),
    .note_strobe (note_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign rom_data = (zero_r1 && rom_addr[8:7] == 2'd1) ? 16'h0000 : rom[rom_addr];

  // Tick generator: one-cycle pulse every 4 clocks, changed just after the rising edge.
  initial begin
    tick = 1'b0;
    tdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv + 1) % 4;
      tick = tick_en && (tdiv == 0);
    end
  end

  always @(negedge clk) if (done) done_seen++;

  function automatic logic [15:0] nw(input int p, input int d);
    logic [5:0] p6;
    logic [5:0] d6;
    p6 = 6'(p);
    d6 = 6'(d);
    return {1'b0, p6, d6, 3'b000};
  endfunction

  function automatic logic [15:0] rw(input int d);
    logic [5:0] d6;
    d6 = 6'(d);
    return {1'b1, d6, 9'd0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] sel);
    song_sel = sel;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Called on the first PLAY cycle of a note; returns on the FETCH cycle that follows it.
  task automatic play_note(input string tag, input int p, input int d);
    int t;
    int n;
    t = 0;
    n = 0;
    chk({tag, "_strobe"}, 32'(note_strobe), 1);
    chk({tag, "_pitch"}, 32'(note), 32'(p));
    chk({tag, "_on"}, 32'(note_on), 1);
    while (note_on && n < 1000) begin
      if (tick) t++;
      step();
      n++;
    end
    chk({tag, "_ticks"}, 32'(t), 32'(d));
  endtask

  task automatic gap(input string tag, input int addr);
    chk({tag, "_gap_on"}, 32'(note_on), 0);
    chk({tag, "_gap_busy"}, 32'(busy), 1);
    chk({tag, "_gap_addr"}, 32'(rom_addr), 32'(addr));
    step();
  endtask

  initial begin
    int t;
    int n;
    int strobes;
    int last_note;
    int last_ticks;
    int prev_addr;
    int max_addr;
    int first_addr;
    int fetches;
    int ds0;
    bit on_seen;
    bit changed;

    total = 0;
    bad = 0;
    done_seen = 0;
    zero_r1 = 1'b0;
    tick_en = 1'b1;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    song_sel = 2'd0;
    loop = 1'b0;

    for (int i = 0; i < 512; i++) rom[i] = rw(0);
    // Song 0
    rom[0] = nw(30, 8);
    rom[1] = nw(33, 8);
    rom[2] = nw(37, 8);
    rom[3] = rw(4);
    rom[4] = nw(32, 2);
    // Song 1: skips between the first and last note, end marker at 191
    rom[128] = nw(59, 2);
    for (int i = 129; i < 190; i++) rom[i] = 16'h0000;
    rom[190] = nw(35, 24);
    // Song 2
    rom[256] = nw(40, 32);
    // Song 3: 32 notes alternating with 1-tick rests, end marker at 447
    for (int k = 0; k < 63; k++) begin
      if (k % 2 == 1)   rom[384 + k] = rw(1);
      else if (k == 0)  rom[384 + k] = nw(48, 1);
      else if (k == 62) rom[384 + k] = nw(48, 32);
      else              rom[384 + k] = nw(10 + k / 2, 1);
    end

    step();
    step();
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_note", 32'(note), 0);
    chk("rst_on", 32'(note_on), 0);
    chk("rst_strobe", 32'(note_strobe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // Song 0 sequence
    do_start(2'd0);
    chk("s0_busy", 32'(busy), 1);
    chk("s0_addr", 32'(rom_addr), 0);
    chk("s0_on_fetch", 32'(note_on), 0);
    step();
    play_note("s0_n30", 30, 8);
    gap("s0_a", 1);
    play_note("s0_n33", 33, 8);
    gap("s0_b", 2);
    play_note("s0_n37", 37, 8);
    t = 0;
    n = 0;
    while (!note_strobe && n < 200) begin
      if (tick) t++;
      if (note_on) t += 100;
      step();
      n++;
    end
    chk("s0_rest_ticks", 32'(t), 4);
    play_note("s0_n32", 32, 2);
    chk("s0_end_addr", 32'(rom_addr), 5);
    step();
    chk("s0_done", 32'(done), 1);
    chk("s0_done_busy", 32'(busy), 0);
    step();
    chk("s0_done_pulse", 32'(done), 0);

    // Song 3 to completion
    do_start(2'd3);
    strobes = 0;
    last_note = -1;
    last_ticks = 0;
    prev_addr = -1;
    n = 0;
    while (!done && n < 3000) begin
      if (note_strobe) begin
        strobes++;
        last_note = int'(note);
        last_ticks = 0;
      end
      if (note_on && tick) last_ticks++;
      prev_addr = int'(rom_addr);
      step();
      n++;
    end
    chk("s3_done", 32'(done), 1);
    chk("s3_busy", 32'(busy), 0);
    chk("s3_strobes", 32'(strobes), 32);
    chk("s3_last_note", 32'(last_note), 48);
    chk("s3_last_ticks", 32'(last_ticks), 32);
    chk("s3_end_addr", 32'(prev_addr), 447);
    step();
    chk("s3_done_pulse", 32'(done), 0);

    // Song 1 looping
    loop = 1'b1;
    ds0 = done_seen;
    do_start(2'd1);
    step();
    chk("s1_first_note", 32'(note), 59);
    chk("s1_first_strobe", 32'(note_strobe), 1);
    n = 0;
    while (!(note_strobe && note == 6'd35) && n < 500) begin
      step();
      n++;
    end
    play_note("s1_n35", 35, 24);
    chk("s1_end_addr", 32'(rom_addr), 191);
    step();
    chk("s1_loop_addr", 32'(rom_addr), 128);
    chk("s1_loop_busy", 32'(busy), 1);
    step();
    chk("s1_loop_note", 32'(note), 59);
    chk("s1_loop_strobe", 32'(note_strobe), 1);
    chk("s1_no_done", 32'(done_seen - ds0), 0);

    // Retrigger to song 3 while song 1 plays
    do_start(2'd3);
    chk("rt_addr", 32'(rom_addr), 384);
    chk("rt_on", 32'(note_on), 0);
    chk("rt_busy", 32'(busy), 1);
    step();
    chk("rt_note", 32'(note), 48);
    chk("rt_strobe", 32'(note_strobe), 1);
    chk("rt_no_done", 32'(done_seen - ds0), 0);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_on", 32'(note_on), 0);
    step();
    chk("ss_idle", 32'(busy), 0);
    loop = 1'b0;

    // Stop during the 4th tick of a 32-tick note
    ds0 = done_seen;
    do_start(2'd2);
    step();
    chk("st_note", 32'(note), 40);
    t = 0;
    n = 0;
    while (t < 3 && n < 200) begin
      if (tick) t++;
      step();
      n++;
    end
    chk("st_on_before", 32'(note_on), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_on", 32'(note_on), 0);
    chk("st_busy", 32'(busy), 0);
    chk("st_note0", 32'(note), 0);
    changed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (note_on || busy || note != 6'd0 || note_strobe) changed = 1'b1;
      step();
    end
    chk("st_quiet", 32'(changed), 0);
    chk("st_no_done", 32'(done_seen - ds0), 0);

    // All-zero region: 128 skips then completion
    zero_r1 = 1'b1;
    do_start(2'd1);
    fetches = 0;
    max_addr = 0;
    first_addr = -1;
    on_seen = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      if (busy) begin
        fetches++;
        if (first_addr < 0) first_addr = int'(rom_addr);
        if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      end
      if (note_on) on_seen = 1'b1;
      step();
      n++;
    end
    chk("z_done", 32'(done), 1);
    chk("z_fetches", 32'(fetches), 128);
    chk("z_first", 32'(first_addr), 128);
    chk("z_max", 32'(max_addr), 255);
    chk("z_no_on", 32'(on_seen), 0);
    chk("z_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_player.md
# song_player

Sequencer that reads the packed note/rest words in the song ROM and turns them into a timed pitch stream for the tone generator. It sits between the emotion-driven song-select logic and the synth. It selects one of four 128-word song regions, fetches entries in order, and holds each pitch or rest for its encoded duration counted in external `tick` pulses. It stops on the end-of-song marker, or loops back to the start of the song when `loop` is set.

## Interface
- No parameters. Word format, region size and count are fixed by the ROM layout.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: 1-cycle request to play `song_sel`. Also accepted while busy, where it retriggers.
- `stop` in 1: 1-cycle abort request.
- `song_sel` in 2: song index; region base = {song_sel, 7'd0}.
- `loop` in 1: sampled at each end marker; 1 = restart the song, 0 = finish.
- `tick` in 1: 1-cycle duration time-base pulse from the external divider.
- `rom_addr` out 9: registered ROM address.
- `rom_data` in 16: combinational ROM word, valid in the same cycle as `rom_addr`.
- `note` out 6: current pitch number. 0 when not sounding.
- `note_on` out 1: high while a note entry is playing.
- `note_strobe` out 1: 1-cycle pulse on the first PLAY cycle of each note entry.
- `busy` out 1: high in FETCH and PLAY.
- `done` out 1: 1-cycle pulse on natural song completion.

## Operation
- Word decode:
  - bit15 = 0: note entry; [14:9] = pitch, [8:3] = duration D, [2:0] ignored.
  - bit15 = 1: rest entry; [14:9] = D, [8:0] ignored.
  - Rest with D = 0: end marker.
  - Note with D = 0: skipped; it takes one FETCH cycle and makes no sound.
- States:
  - IDLE: on `start`, `rom_addr` <= {song_sel, 7'd0}; go to FETCH.
  - FETCH (one cycle per entry): decode `rom_data`.
    - Note, D > 0: `cnt` <= D, `note` <= pitch, `note_on` <= 1, `note_strobe` <= 1; go to PLAY.
    - Rest, D > 0: `cnt` <= D, `note` <= 0, `note_on` <= 0; go to PLAY.
    - Zero-length note: advance the address; stay in FETCH.
    - End marker, `loop` = 1: `rom_addr` <= region base; stay in FETCH.
    - End marker, `loop` = 0: go to IDLE; pulse `done`.
  - PLAY:
    - `tick` with `cnt` > 1: decrement `cnt`.
    - `tick` with `cnt` == 1: `note_on` <= 0, `note` <= 0, advance the address; go to FETCH.
- Address advance: increments only the low 7 bits; bits [8:7] never change during a song.
  - If the low 7 bits = 127 when advancing, treat the advance as an end marker (same `loop`/`done` handling).
  - A region with no marker therefore never spills into the next song.
- Priority, highest first:
  - `rst`: IDLE, all outputs 0.
  - `stop` (any state): IDLE next cycle; `note`, `note_on` and `busy` = 0; `done` not pulsed.
  - `start` in FETCH or PLAY: retrigger. `rom_addr` <= new base, `cnt` cleared, `note_on` <= 0, go to FETCH; `done` not pulsed.
- `tick` in IDLE or FETCH is ignored and not banked.
- `cnt` is 6 bits; maximum D is 63 ticks.

## Timing
- Reset values: `rom_addr` = 0, `note` = 0, `note_on` = 0, `note_strobe` = 0, `busy` = 0, `done` = 0, `cnt` = 0, state IDLE.
- `start` sampled at edge E0:
  - After E0: FETCH, `rom_addr` = base, `busy` = 1.
  - After E1: PLAY, with `note`/`note_on`/`note_strobe` valid.
- Start-to-sound latency: 2 cycles.
- An entry of D ticks sounds from its PLAY entry to the edge that samples the D-th `tick`.
- Between consecutive entries there is exactly 1 FETCH cycle with `note_on` = 0.
- `done` rises the cycle after the end-marker FETCH, coincident with `busy` falling.

## Test plan
- Song 0, `tick` every 4 clk, `loop` = 0, `start` with `song_sel` = 0:
  - `rom_addr` = 0; 2 cycles later `note` = 30, `note_on` = 1, `note_strobe` pulses.
  - `note` = 30 holds for 8 ticks.
  - Then 1 gap cycle, then 33 for 8 ticks, 37 for 8 ticks, a 4-tick rest with `note_on` = 0, then 32.
- Song 3 to completion:
  - Last note is 48 for 32 ticks.
  - FETCH then reads `rom_addr` = 447 (end marker); `done` pulses once, `busy` = 0.
  - Total `note_strobe` count = 32.
- `loop` = 1 on song 1:
  - After the 24-tick note 35 at address 190, address 191 is followed by `rom_addr` = 128 and `note` = 59.
  - No `done` pulse.
- `stop` midway through the 4th tick of a 32-tick note in song 2:
  - Next cycle: `note_on` = 0, `busy` = 0, no `done`.
  - Subsequent ticks produce no output change.
- Retrigger: `start` with `song_sel` = 3 while playing song 1:
  - Next cycle `rom_addr` = 384; 2 cycles after `start`, `note` = 48.
  - `start` and `stop` in the same cycle: `stop` wins, state IDLE.
- Bench ROM model returning 16'h0000 for all of region 1:
  - 128 consecutive skip FETCH cycles (`rom_addr` 128..255), then `done`.
  - `rom_addr` never reaches 256; `note_on` is never asserted.
